// File: rtl/frame_stack16b_pkg.sv
// Shared definitions for the call-frame stack: register/frame widths,
// FSM state encoding and a helper that extracts one register word from a frame.
package frame_stack16b_pkg;

  localparam int WORD_W     = 16;
  localparam int FRAME_REGS = 15;
  localparam int FRAME_W    = WORD_W * FRAME_REGS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RESTORE = 2'd3
  } state_t;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Word k of a frame lives at bits [16k+15:16k].
  function automatic word_t frame_word(input frame_t f, input logic [3:0] k);
    return f[WORD_W*int'(k) +: WORD_W];
  endfunction

endpackage

// File: rtl/frame_stack16b_if.sv
// Control/register-file side bundle of the frame stack.
//   push, pop   : request pulses from control (master -> slave)
//   frameIn     : live register-file frame (master -> slave)
//   frameOut    : restored frame, stable while restore=1 (slave -> master)
//   restore     : one-cycle load strobe for the register file
//   busy, full, empty, overflow, underflow, depth : status
//
// Handshake: push and pop are single-cycle requests. A request is taken
// only on a cycle where busy=0; while busy=1 requests are dropped without
// any flag. If push and pop arrive together while idle, push wins.
// Completion is signalled by busy falling (save) or by restore (load).
interface frame_stack16b_if #(
  parameter int DEPTH = 16
);
  import frame_stack16b_pkg::*;

  localparam int SP_W = $clog2(DEPTH) + 1;

  logic            push;
  logic            pop;
  frame_t          frameIn;
  frame_t          frameOut;
  logic            restore;
  logic            busy;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            underflow;
  logic [SP_W-1:0] depth;

  modport master (
    output push, pop, frameIn,
    input  frameOut, restore, busy, full, empty, overflow, underflow, depth
  );

  modport slave (
    input  push, pop, frameIn,
    output frameOut, restore, busy, full, empty, overflow, underflow, depth
  );

endinterface

// File: rtl/frame_ram16.sv
// Single-port word RAM backing the frame stack.
//   clk   : clock
//   we    : write enable, writes wdata to addr at posedge
//   addr  : word address
//   wdata : write data
//   rdata : registered read of addr (one-cycle latency)
module frame_ram16
  import frame_stack16b_pkg::*;
#(
  parameter int WORDS = 240,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/frame_stack16b.sv
// Call-frame save/restore stack. A push snapshots the 15-register frame and
// streams it word by word into the stack RAM; a pop streams it back into
// frameOut and then pulses restore for one cycle.
//   clk       : clock
//   reset     : synchronous, active-high
//   bus       : frame_stack16b_if slave (requests, frames, status)
//   state_dbg : current FSM state
module frame_stack16b
  import frame_stack16b_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  frame_stack16b_if.slave bus,
  output state_t        state_dbg
);

  localparam int SP_W      = $clog2(DEPTH) + 1;
  localparam int RAM_WORDS = DEPTH * FRAME_REGS;
  localparam int AW        = $clog2(RAM_WORDS);

  state_t          state, state_nx;
  logic [SP_W-1:0] sp, sp_nx;
  logic [3:0]      k, k_nx;
  logic [3:0]      k_addr;
  frame_t          snap;
  frame_t          frame_out_q;
  logic            ovf_q, unf_q;
  logic            ovf_set, unf_set;
  logic            snap_ld;
  logic            cap_en;
  logic            full, empty;

  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  word_t           ram_wdata;
  word_t           ram_rdata;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  // LOAD runs one extra cycle (k=15) only to catch the last read; keep the
  // address inside the frame for that cycle.
  assign k_addr    = (k == 4'd15) ? 4'd14 : k;
  assign ram_addr  = AW'(sp) * AW'(FRAME_REGS) + AW'(k_addr);
  assign ram_wdata = frame_word(snap, k);

  always_comb begin
    state_nx = state;
    sp_nx    = sp;
    k_nx     = k;
    snap_ld  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    cap_en   = 1'b0;
    ram_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.push) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            snap_ld  = 1'b1;
            k_nx     = 4'd0;
            state_nx = ST_SAVE;
          end
        end else if (bus.pop) begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            // Decrement first so LOAD addresses the top frame directly.
            sp_nx    = sp - 1'b1;
            k_nx     = 4'd0;
            state_nx = ST_LOAD;
          end
        end
      end
      ST_SAVE: begin
        ram_we = 1'b1;
        if (k == 4'd14) begin
          sp_nx    = sp + 1'b1;
          k_nx     = 4'd0;
          state_nx = ST_IDLE;
        end else begin
          k_nx = k + 4'd1;
        end
      end
      ST_LOAD: begin
        // Read data for address k arrives when the counter shows k+1.
        cap_en = (k != 4'd0);
        if (k == 4'd15) begin
          k_nx     = 4'd0;
          state_nx = ST_RESTORE;
        end else begin
          k_nx = k + 4'd1;
        end
      end
      ST_RESTORE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sp          <= '0;
      k           <= 4'd0;
      frame_out_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state <= state_nx;
      sp    <= sp_nx;
      k     <= k_nx;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end
      if (cap_en) begin
        frame_out_q[WORD_W*int'(k - 4'd1) +: WORD_W] <= ram_rdata;
      end
    end
  end

  // Snapshot is pure datapath; its content only matters after a push.
  always_ff @(posedge clk) begin
    if (snap_ld) begin
      snap <= bus.frameIn;
    end
  end

  frame_ram16 #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.frameOut  = frame_out_q;
  assign bus.restore   = (state == ST_RESTORE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.depth     = sp;
  assign state_dbg     = state;

endmodule
